// File: rtl/bus_arbiter.sv
// Two-requester round-robin bus arbiter driving a single-slave-port bus.
// Latency: req sampled in IDLE -> ack two cycles later; one transaction per 3 cycles.
// Backpressure: requesters hold req until their one-cycle ack; the loser simply waits.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   req*/we*/a*/wd*        requester command (held until ack)
//   ack*/rd*               one-cycle completion pulse and read data valid with it
//   gnt0/gnt1              one-hot current owner, both low in IDLE
//   bus_we/bus_a/bus_wd    decoder/slave side command
//   bus_rd                 combinational read data from the slave mux
module bus_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic [31:0] wd0,
  input  logic [31:0] wd1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rd0,
  output logic [31:0] rd1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        bus_we,
  output logic [31:0] bus_a,
  output logic [31:0] bus_wd,
  input  logic [31:0] bus_rd
);

  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

  state_t      state;
  logic        ptr;     // requester favoured on a tie
  logic        owner;   // requester holding the bus in ADDR/RESP
  logic        lat_we;
  logic [31:0] lat_a;
  logic [31:0] lat_wd;
  logic [31:0] rd_reg;
  logic        win;

  // Lone requester wins outright; on a tie the pointer decides.
  assign win = (req0 && req1) ? ptr : req1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= 1'b0;
      owner  <= 1'b0;
      lat_we <= 1'b0;
      lat_a  <= '0;
      lat_wd <= '0;
      rd_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner  <= win;
            ptr    <= ~win;
            lat_we <= win ? we1 : we0;
            lat_a  <= win ? a1  : a0;
            lat_wd <= win ? wd1 : wd0;
            state  <= ADDR;
          end
        end
        ADDR: begin
          rd_reg <= bus_rd;
          state  <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Every output is decoded from flops only, so reset clears them
  // immediately and nothing depends on requester inputs after the grant edge.
  assign gnt0   = (state != IDLE) && !owner;
  assign gnt1   = (state != IDLE) &&  owner;
  assign bus_we = (state == ADDR) && lat_we;
  assign bus_a  = lat_a;
  assign bus_wd = lat_wd;
  assign ack0   = (state == RESP) && !owner;
  assign ack1   = (state == RESP) &&  owner;
  assign rd0    = ack0 ? rd_reg : '0;
  assign rd1    = ack1 ? rd_reg : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        r_req [2];
  logic        r_we  [2];
  logic [31:0] r_a   [2];
  logic [31:0] r_wd  [2];
  logic        rd_force = 1'b0;

  logic        ack0, ack1, gnt0, gnt1, bus_we;
  logic [31:0] rd0, rd1, bus_a, bus_wd, bus_rd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] slave_fn(input logic [31:0] x);
    return {x[15:0], ~x[31:16]} ^ 32'h5A5A_1234;
  endfunction

  // Simple slave: read data is a fixed function of the address.
  assign bus_rd = rd_force ? 32'hDEAD_BEEF : slave_fn(bus_a);

  bus_arbiter dut (
    .clk    (clk),
    .rst    (rst),
    .req0   (r_req[0]),
    .req1   (r_req[1]),
    .we0    (r_we[0]),
    .we1    (r_we[1]),
    .a0     (r_a[0]),
    .a1     (r_a[1]),
    .wd0    (r_wd[0]),
    .wd1    (r_wd[1]),
    .ack0   (ack0),
    .ack1   (ack1),
    .rd0    (rd0),
    .rd1    (rd1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .bus_we (bus_we),
    .bus_a  (bus_a),
    .bus_wd (bus_wd),
    .bus_rd (bus_rd)
  );

  // Transaction-level reference: phase 0 = no transaction, 1 = address
  // cycle, 2 = response cycle of the transaction in flight.
  int          m_phase;
  int          m_owner;
  int          m_pref;
  logic        m_we;
  logic [31:0] m_a, m_wd, m_rd;
  int          grants[$];
  int          ack_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_pref = 0;
    m_we = 1'b0; m_a = '0; m_wd = '0; m_rd = '0;
  endtask

  task automatic check_outputs();
    logic e_ack0, e_ack1;
    e_ack0 = (m_phase == 2) && (m_owner == 0);
    e_ack1 = (m_phase == 2) && (m_owner == 1);
    check("gnt0",   gnt0,   (m_phase != 0) && (m_owner == 0));
    check("gnt1",   gnt1,   (m_phase != 0) && (m_owner == 1));
    check("bus_we", bus_we, (m_phase == 1) && m_we);
    check("bus_a",  bus_a,  m_a);
    check("bus_wd", bus_wd, m_wd);
    check("ack0",   ack0,   e_ack0);
    check("ack1",   ack1,   e_ack1);
    check("rd0",    rd0,    e_ack0 ? m_rd : 32'h0);
    check("rd1",    rd1,    e_ack1 ? m_rd : 32'h0);
  endtask

  // Advance the model by one clock using the inputs currently driven,
  // clock the DUT, then compare at the following falling edge.
  task automatic step();
    int w;
    if (rst) begin
      model_reset();
    end else begin
      case (m_phase)
        0: if (r_req[0] || r_req[1]) begin
             w = (r_req[0] && r_req[1]) ? m_pref : (r_req[1] ? 1 : 0);
             m_owner = w;
             m_pref  = 1 - w;
             m_we = r_we[w]; m_a = r_a[w]; m_wd = r_wd[w];
             grants.push_back(w);
             m_phase = 1;
           end
        1: begin
             m_rd = rd_force ? 32'hDEAD_BEEF : slave_fn(m_a);
             m_phase = 2;
           end
        default: m_phase = 0;
      endcase
    end
    @(posedge clk);
    @(negedge clk);
    if (ack0 || ack1) ack_seen++;
    check_outputs();
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      r_req[i] = 1'b0; r_we[i] = 1'b0; r_a[i] = '0; r_wd[i] = '0;
    end
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    grants.delete();
    ack_seen = 0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      r_req[i] = 1'b0; r_we[i] = 1'b0; r_a[i] = '0; r_wd[i] = '0;
    end
    model_reset();
    ack_seen = 0;
    @(negedge clk);
    do_reset();

    // Single write from requester 0.
    r_req[0] = 1'b1; r_we[0] = 1'b1; r_a[0] = 32'h800; r_wd[0] = 32'd5;
    step();
    check("wr_bus_we", bus_we, 1'b1);
    check("wr_bus_a",  bus_a,  32'h800);
    check("wr_bus_wd", bus_wd, 32'd5);
    check("wr_gnt0",   gnt0,   1'b1);
    step();
    check("wr_ack0",   ack0,   1'b1);
    check("wr_we_low", bus_we, 1'b0);
    r_req[0] = 1'b0;
    step();

    // Single read from requester 1 with a forced slave value.
    r_req[1] = 1'b1; r_we[1] = 1'b0; r_a[1] = 32'h904; rd_force = 1'b1;
    step();
    step();
    check("rd_ack1", ack1, 1'b1);
    check("rd_rd1",  rd1,  32'hDEAD_BEEF);
    check("rd_ack0", ack0, 1'b0);
    check("rd_rd0",  rd0,  32'h0);
    r_req[1] = 1'b0; rd_force = 1'b0;
    step();

    // Requester changes its address and drops req during ADDR.
    r_req[0] = 1'b1; r_we[0] = 1'b0; r_a[0] = 32'hFFFF_FFFC;
    step();
    r_a[0] = 32'h123; r_req[0] = 1'b0;
    step();
    check("stab_bus_a", bus_a, 32'hFFFF_FFFC);
    check("stab_ack0",  ack0,  1'b1);
    step();
    check("stab_no_2nd_ack", ack0, 1'b0);

    // Reset in the middle of a write address cycle.
    r_req[0] = 1'b1; r_we[0] = 1'b1; r_a[0] = 32'h40; r_wd[0] = 32'h77;
    step();
    check("arst_pre_we", bus_we, 1'b1);
    rst = 1'b1;
    r_req[0] = 1'b0;
    #1;
    check("arst_we",   bus_we, 1'b0);
    check("arst_gnt0", gnt0,   1'b0);
    check("arst_gnt1", gnt1,   1'b0);
    check("arst_ack0", ack0,   1'b0);
    check("arst_ack1", ack1,   1'b0);
    model_reset();
    step();
    rst = 1'b0;
    ack_seen = 0;
    for (int i = 0; i < 4; i++) step();
    check("arst_no_ack", ack_seen, 0);

    // Both requesting continuously from reset: strict alternation.
    do_reset();
    r_req[0] = 1'b1; r_req[1] = 1'b1;
    r_a[0] = 32'hA000_0000; r_a[1] = 32'hB000_0000;
    for (int i = 0; i < 12; i++) step();
    check("cont_acks",   ack_seen, 4);
    check("cont_grants", grants.size(), 4);
    for (int i = 0; i < grants.size(); i++)
      check("cont_order", grants[i], i % 2);

    // Randomized traffic; requesters follow the protocol, with occasional
    // early req drop and command changes after the grant.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (m_phase != 0 && m_owner == i) begin
          if (m_phase == 2) r_req[i] = 1'b0;
          else begin
            if ($urandom_range(0, 3) == 0) r_req[i] = 1'b0;
            r_we[i] = 1'($urandom);
            r_a[i]  = $urandom;
            r_wd[i] = $urandom;
          end
        end else if (!r_req[i] && $urandom_range(0, 2) == 0) begin
          r_req[i] = 1'b1;
          r_we[i]  = 1'($urandom);
          r_a[i]   = $urandom;
          r_wd[i]  = $urandom;
        end
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 req0, req1  input  1 each  requester 0/1 wants a bus transaction; held high until its ack.
REQ-005 we0, we1  input  1 each  requester write enable (1 = write, 0 = read).
REQ-006 a0, a1  input  32 each  requester byte address.
REQ-007 wd0, wd1  input  32 each  requester write data.
REQ-008 ack0, ack1  output  1 each  one-cycle pulse; the requester's transaction is complete.
REQ-009 rd0, rd1  output  32 each  read data to the requester; valid while its ack is high.
REQ-010 gnt0, gnt1  output  1 each  one-hot current bus owner; both low when idle.
REQ-011 bus_we  output  1  write enable to the address decoder.
REQ-012 bus_a  output  32  address to the address decoder.
REQ-013 bus_wd  output  32  write data to the slaves.
REQ-014 bus_rd  input  32  combinational read data from the slave read mux, selected by bus_a.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ADDR and RESP.
REQ-016 In IDLE with any req high, the next edge SHALL select a winner, latch its we, a and wd into internal registers, set the owner, and move to ADDR.
REQ-017 Winner selection SHALL be as follows:
- only one req high: that requester wins;
- both high: the requester named by the round-robin pointer wins.
REQ-018 On each grant, the pointer SHALL be set to the requester that did not win.
REQ-019 In ADDR:
- bus_a and bus_wd SHALL equal the latched values;
- bus_we SHALL equal the latched we;
- the next edge SHALL capture bus_rd into a 32-bit read register and move to RESP.
REQ-020 In RESP:
- the owner's ack SHALL be high for exactly one cycle;
- the owner's rd SHALL equal the read register;
- bus_we SHALL be 0 and bus_a SHALL hold the latched address;
- the next edge SHALL move to IDLE.
REQ-021 gnt0/gnt1 SHALL reflect the owner in ADDR and RESP, and SHALL both be 0 in IDLE.
REQ-022 Latency from req sampled high in IDLE to ack high SHALL be 2 cycles; sustained throughput SHALL be one transaction per 3 cycles.
REQ-023 bus_we SHALL be high only in ADDR, and for at most one cycle per write transaction.
REQ-024 When bus_we is 0, bus_a and bus_wd SHALL hold their last latched values; in IDLE after reset they SHALL be 0.
REQ-025 The non-owner's ack SHALL be 0 and its rd SHALL be 0.
REQ-026 The owner's rd SHALL be 0 outside RESP.
REQ-027 If the owner drops req during ADDR or RESP, the transaction SHALL complete unchanged and ack SHALL still pulse.
REQ-028 Changes on requester we/a/wd after the grant edge SHALL NOT affect the bus.
REQ-029 A req still high in the RESP cycle SHALL be treated as a new request in the following IDLE cycle; requesters deassert req in the ack cycle to avoid a duplicate.
REQ-030 The address range is not checked; all 32 address bits SHALL pass to bus_a unmodified.

Reset
REQ-031 On rst high, asynchronously:
- state SHALL be IDLE and the pointer SHALL favour requester 0;
- the latched we, a, wd and the read register SHALL be 0;
- all outputs SHALL be 0.
REQ-032 rst asserted mid-transaction SHALL abort it with no ack; a write aborted in ADDR SHALL have bus_we fall immediately.
REQ-033 The first edge after rst deasserts SHALL be treated as IDLE arbitration.

Verification
REQ-034 Reset: assert rst mid-write in ADDR -> bus_we, gnt0/gnt1 and ack0/ack1 go 0 without waiting for a clock edge; no ack follows.
REQ-035 Single write: req0=1, we0=1, a0=0x800, wd0=5 -> next cycle bus_we=1, bus_a=0x800, bus_wd=5, gnt0=1; the cycle after that, ack0=1 and bus_we=0.
REQ-036 Single read: req1=1, we1=0, a1=0x904, bus_rd=0xDEADBEEF in ADDR -> in RESP, ack1=1 and rd1=0xDEADBEEF, with ack0=0 and rd0=0.
REQ-037 Contention: req0=req1=1 held continuously from reset -> grants alternate 0,1,0,1 with one ack every 3 cycles.
REQ-038 Stability: after the grant, change a0 to 0x123 and drop req0 in ADDR -> bus_a stays at the original address and ack0 still pulses once.
